imm_encoder: RTL and testbench

Pipelined RV32I instruction encoder. It is the inverse of the immediate generator: it takes a format tag, register/function fields and a 32-bit signed immediate, range-checks the immediate for that format, and packs everything into a 32-bit instruction word. It feeds the test-program/instruction-memory loader and self-checking benches, using valid/ready handshakes on both sides.

---
 rtl/imm_encoder.sv | 172 +++++++++++++++++
 tb/tb_imm_encoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage RV32I instruction encoder.
// Stage 1 registers the request fields together with the immediate range
// check. Stage 2 packs the instruction word and presents it on the output
// handshake. A word that fails the range check, or that has an illegal
// format, leaves as a canonical NOP with out_err set.
module imm_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] count_ok,
   output logic [CNT_W-1:0] count_err
);

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Stage 1 state
   logic        s1_valid_q;
   logic [2:0]  s1_fmt_q;
   logic [6:0]  s1_opcode_q;
   logic [4:0]  s1_rd_q;
   logic [4:0]  s1_rs1_q;
   logic [4:0]  s1_rs2_q;
   logic [2:0]  s1_funct3_q;
   logic [6:0]  s1_funct7_q;
   logic [31:0] s1_imm_q;
   logic        s1_err_q;
   logic        s1_err_d;

   // Stage 2 state
   logic        s2_valid_q;
   logic [31:0] s2_instr_q;
   logic [31:0] s2_instr_d;
   logic        s2_err_q;

   logic [CNT_W-1:0] count_ok_q, count_ok_d;
   logic [CNT_W-1:0] count_err_q, count_err_d;

   logic adv1, adv2, out_xfer;
   logic signed [31:0] imm_s;

   // A stage may advance when it is empty or the stage after it is moving.
   assign adv2     = !s2_valid_q || out_ready;
   assign adv1     = !s1_valid_q || adv2;
   assign in_ready = adv1 && !rst;
   assign out_xfer = s2_valid_q && out_ready;
   assign imm_s    = in_imm;

   // Range check of the incoming immediate for its format.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
      s1_err_d = 1'b0;
      case (in_fmt)
         FMT_R:        s1_err_d = 1'b0;
         FMT_I, FMT_S: s1_err_d = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
         FMT_B:        s1_err_d = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || in_imm[0];
         FMT_U:        s1_err_d = |in_imm[11:0];
         FMT_J:        s1_err_d = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || in_imm[0];
         default:      s1_err_d = 1'b1;
      endcase
   end

   // Stage 1: capture request fields and the range-check verdict.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         s1_valid_q <= 1'b0;
      end else if (adv1) begin
         s1_valid_q <= in_valid;
      end
      // NOTE: payload registers carry no reset; the valid bit alone qualifies them.
      if (!rst && adv1 && in_valid) begin
         s1_fmt_q    <= in_fmt;
         s1_opcode_q <= in_opcode;
         s1_rd_q     <= in_rd;
         s1_rs1_q    <= in_rs1;
         s1_rs2_q    <= in_rs2;
         s1_funct3_q <= in_funct3;
         s1_funct7_q <= in_funct7;
         s1_imm_q    <= in_imm;
         s1_err_q    <= s1_err_d;
      end
   end

   // Pack the stage-1 fields into the instruction word, or a NOP on error.
   always_comb begin
      s2_instr_d = NOP_INSTR;
      if (!s1_err_q) begin
         case (s1_fmt_q)
            FMT_R: s2_instr_d = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_I: s2_instr_d = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_S: s2_instr_d = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                 s1_imm_q[4:0], s1_opcode_q};
            FMT_B: s2_instr_d = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                 s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            FMT_U: s2_instr_d = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            FMT_J: s2_instr_d = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                 s1_rd_q, s1_opcode_q};
            default: s2_instr_d = NOP_INSTR;
         endcase
      end
   end

   // Stage 2: output register; holds its word while the consumer stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_instr_q <= '0;
         s2_err_q   <= 1'b0;
      end else if (adv2) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s1_err_q;
         end
      end
   end

   // Saturating delivery counters, stepped only on an output transfer.
   always_comb begin
      count_ok_d  = count_ok_q;
      count_err_d = count_err_q;
      if (out_xfer) begin
         if (!s2_err_q) begin
            if (count_ok_q != {CNT_W{1'b1}}) count_ok_d = count_ok_q + 1'b1;
         end else begin
            if (count_err_q != {CNT_W{1'b1}}) count_err_d = count_err_q + 1'b1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_ok_q  <= '0;
         count_err_q <= '0;
      end else begin
         count_ok_q  <= count_ok_d;
         count_err_q <= count_err_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out_instr = s2_instr_q;
   assign out_err   = s2_err_q;
   assign count_ok  = count_ok_q;
   assign count_err = count_err_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Testbench for imm_encoder: table of encode vectors with a scoreboard queue,
// plus backpressure, mid-stream reset and counter saturation sequences.
// A second instance with 2-bit counters shares all inputs.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_ready2;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [31:0] out_instr, out_instr2;
   logic        out_err, out_err2;
   logic [15:0] count_ok, count_err;
   logic [1:0]  count_ok2, count_err2;

   always #5 clk = ~clk;

   imm_encoder #(.CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_err(out_err), .count_ok(count_ok), .count_err(count_err)
   );

   imm_encoder #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
      .out_err(out_err2), .count_ok(count_ok2), .count_err(count_err2)
   );

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] instr;
      logic        err;
   } vec_t;

   typedef struct packed {
      logic        err;
      logic [31:0] instr;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];
   exp_t drv_exp;
   exp_t e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_acc    = 0;
   logic [15:0] m_ok, m_err;
   logic [1:0]  m_ok2, m_err2;
   logic        stall_prev;
   exp_t        held;
   logic        rand_rdy = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm,
                               input logic [31:0] instr, input logic err);
      vec_t v;
      v.fmt = fmt; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.f3 = f3; v.f7 = f7; v.imm = imm; v.instr = instr; v.err = err;
      return v;
   endfunction

   // Advance to just after the n-th next rising edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one request and hold it until it is accepted (bounded).
   task automatic send(input vec_t v);
      int n0;
      n0 = n_acc;
      in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
      in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
      drv_exp = '{err: v.err, instr: v.instr};
      in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (n_acc != n0) break;
      end
      if (n_acc == n0) check("accept_timeout", 64'(n_acc - n0), 64'd1);
      in_valid = 1'b0;
   endtask

   // Wait for the scoreboard to empty and the output to go idle (bounded).
   task automatic drain();
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         cyc(1);
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Cycles from accept edge (counted as 1) until out_valid shows.
   task automatic latency_check(input string name);
      int lat;
      lat = 1;
      while (!out_valid && lat < 10) begin
         cyc(1);
         lat++;
      end
      check(name, 64'(lat), 64'd2);
   endtask

   // Monitor/scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_prev = 1'b0;
         m_ok = '0; m_err = '0; m_ok2 = '0; m_err2 = '0;
      end else begin
         check("count_ok", 64'(count_ok), 64'(m_ok));
         check("count_err", 64'(count_err), 64'(m_err));
         check("sat_count_ok", 64'(count_ok2), 64'(m_ok2));
         check("sat_count_err", 64'(count_err2), 64'(m_err2));
         if (stall_prev) check("hold_stable", 64'({out_err, out_instr}), 64'(held));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_word: got %0h with nothing outstanding (t=%0t)", out_instr, $time);
            end else begin
               e = exp_q.pop_front();
               check("word", 64'({out_err, out_instr}), 64'(e));
               if (!e.err) begin
                  if (m_ok != 16'hFFFF) m_ok = m_ok + 1'b1;
                  if (m_ok2 != 2'b11) m_ok2 = m_ok2 + 1'b1;
               end else begin
                  if (m_err != 16'hFFFF) m_err = m_err + 1'b1;
                  if (m_err2 != 2'b11) m_err2 = m_err2 + 1'b1;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(drv_exp);
            n_acc++;
         end
         stall_prev = out_valid && !out_ready;
         held = '{err: out_err, instr: out_instr};
      end
   end

   // Random consumer readiness while enabled.
   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;

      //           fmt op     rd rs1 rs2 f3 f7     imm           instr          err
      vecs.push_back(mk(1, 7'h13, 5, 2, 0, 0, 0,     -3,          32'hFFD10293, 0));
      vecs.push_back(mk(1, 7'h13, 5, 2, 0, 0, 0,     2048,        32'h00000013, 1));
      vecs.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0,     2047,        32'h7FF00013, 0));
      vecs.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0,     -2048,       32'h80000013, 0));
      vecs.push_back(mk(1, 7'h13, 0, 0, 0, 0, 0,     -2049,       32'h00000013, 1));
      vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0,     16,          32'h0100006F, 0));
      vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0,     -8,          32'hFF9FF06F, 0));
      vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0,     1048576,     32'h00000013, 1));
      vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0,     1048574,     32'h7FFFF06F, 0));
      vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0,     -1048576,    32'h8000006F, 0));
      vecs.push_back(mk(5, 7'h6F, 0, 0, 0, 0, 0,     3,           32'h00000013, 1));
      vecs.push_back(mk(3, 7'h63, 0, 11, 12, 0, 0,   12,          32'h00C58663, 0));
      vecs.push_back(mk(3, 7'h63, 0, 11, 12, 0, 0,   13,          32'h00000013, 1));
      vecs.push_back(mk(3, 7'h63, 0, 11, 12, 0, 0,   4094,        32'h7EC58FE3, 0));
      vecs.push_back(mk(3, 7'h63, 0, 11, 12, 0, 0,   -4096,       32'h80C58063, 0));
      vecs.push_back(mk(3, 7'h63, 0, 11, 12, 0, 0,   4096,        32'h00000013, 1));
      vecs.push_back(mk(2, 7'h23, 0, 2, 11, 2, 0,    0,           32'h00B12023, 0));
      vecs.push_back(mk(2, 7'h23, 0, 2, 11, 2, 0,    2047,        32'h7EB12FA3, 0));
      vecs.push_back(mk(2, 7'h23, 0, 2, 11, 2, 0,    -2049,       32'h00000013, 1));
      vecs.push_back(mk(4, 7'h37, 0, 0, 0, 0, 0,     32'h12345000, 32'h12345037, 0));
      vecs.push_back(mk(4, 7'h37, 0, 0, 0, 0, 0,     32'h12345001, 32'h00000013, 1));
      vecs.push_back(mk(0, 7'h33, 3, 1, 2, 0, 0,     32'hDEADBEEF, 32'h002081B3, 0));
      vecs.push_back(mk(0, 7'h33, 3, 1, 2, 0, 7'h20, 32'hDEADBEEF, 32'h402081B3, 0));
      vecs.push_back(mk(6, 7'h13, 1, 1, 1, 0, 0,     0,           32'h00000013, 1));
      vecs.push_back(mk(7, 7'h13, 1, 1, 1, 0, 0,     0,           32'h00000013, 1));

      // Reset state
      cyc(2);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check("rst_count_ok", 64'(count_ok), 64'd0);
      check("rst_count_err", 64'(count_err), 64'd0);
      rst = 1'b0;
      cyc(1);

      // Single word latency
      out_ready = 1'b1;
      send(vecs[0]);
      latency_check("latency");
      drain();

      // Table sweep with a randomly stalling consumer
      rand_rdy = 1'b1;
      foreach (vecs[i]) send(vecs[i]);
      rand_rdy = 1'b0;
      cyc(1);
      out_ready = 1'b1;
      drain();
      check("sat_ok_after_table", 64'(count_ok2), 64'd3);
      check("sat_err_after_table", 64'(count_err2), 64'd3);

      // Backpressure: four back-to-back words, consumer stalled for 5 cycles
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      out_ready = 1'b0;
      base = n_acc;
      fork
         begin
            send(vecs[0]); send(vecs[2]); send(vecs[3]); send(vecs[5]);
         end
         begin
            cyc(5);
            check("bp_accepts", 64'(n_acc - base), 64'd2);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_instr", 64'(out_instr), 64'(vecs[0].instr));
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count_ok", 64'(count_ok), 64'd4);
      check("bp_count_err", 64'(count_err), 64'd0);
      check("bp_sat_count_ok", 64'(count_ok2), 64'd3);

      // Reset with two words in flight
      out_ready = 1'b0;
      send(vecs[6]);
      send(vecs[9]);
      rst = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      cyc(1);
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_count_ok", 64'(count_ok), 64'd0);
      check("mid_rst_count_err", 64'(count_err), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         check("no_stale_word", 64'(out_valid), 64'd0);
      end
      send(vecs[11]);
      latency_check("post_rst_latency");
      drain();
      check("post_rst_count_ok", 64'(count_ok), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
